nfc_command_dispatcher: RTL and testbench

//  Shares one atom-command-generator (ACG) bus between NumOfCmdModules command sequencers (reset, read, program, erase, ...).

---
 rtl/nfc_command_dispatcher_pkg.sv | 29 ++
 rtl/nfc_acg_bus_mux.sv | 47 ++++
 rtl/nfc_command_dispatcher.sv | 127 ++++++++++++
 tb/tb_nfc_command_dispatcher.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_command_dispatcher_pkg.sv
// nfc_command_dispatcher_pkg: shared types and constants for the ACG command dispatcher
//   dispState_t       one-hot dispatcher FSM state
//   Idle*             pattern the ACG bus carries when no sequencer holds the grant
//   CmdBit*           bit positions of the one-hot ACG command byte
package nfc_command_dispatcher_pkg;

    typedef enum logic [3:0] {
        sIdle   = 4'b0001,
        sActive = 4'b0010,
        sDone   = 4'b0100,
        sTout   = 4'b1000
    } dispState_t;

    localparam logic [7:0]  IdleCommand       = 8'h00;
    localparam logic [2:0]  IdleCommandOption = 3'b000;
    localparam logic [15:0] IdleNumOfData     = 16'h0000;
    localparam logic        IdleCASelect      = 1'b1;
    localparam logic [39:0] IdleCAData        = 40'h00_0000_0000;

    localparam int CmdBitCAOut     = 0;
    localparam int CmdBitDataOut   = 1;
    localparam int CmdBitDataIn    = 2;
    localparam int CmdBitTimer     = 3;
    localparam int CmdBitStatus    = 4;
    localparam int CmdBitReset     = 5;
    localparam int CmdBitSetFeat   = 6;
    localparam int CmdBitGetFeat   = 7;

endpackage

// File: rtl/nfc_acg_bus_mux.sv
// nfc_acg_bus_mux: routes the granted sequencer's ACG fields onto the shared bus
//   iGrant        index of the granted sequencer
//   iActive       grant is live; otherwise the bus carries the idle pattern
//   iCM_*         packed per-sequencer ACG fields, sequencer k in slice k
//   oACG_*        shared ACG bus
module nfc_acg_bus_mux
    import nfc_command_dispatcher_pkg::*;
#(
    parameter int NumberOfWays    = 4,
    parameter int NumOfCmdModules = 4
) (
    input  logic [2:0]                              iGrant,
    input  logic                                    iActive,
    input  logic [8*NumOfCmdModules-1:0]            iCM_Command,
    input  logic [3*NumOfCmdModules-1:0]            iCM_CommandOption,
    input  logic [NumberOfWays*NumOfCmdModules-1:0] iCM_TargetWay,
    input  logic [16*NumOfCmdModules-1:0]           iCM_NumOfData,
    input  logic [NumOfCmdModules-1:0]              iCM_CASelect,
    input  logic [40*NumOfCmdModules-1:0]           iCM_CAData,
    output logic [7:0]                              oACG_Command,
    output logic [2:0]                              oACG_CommandOption,
    output logic [NumberOfWays-1:0]                 oACG_TargetWay,
    output logic [15:0]                             oACG_NumOfData,
    output logic                                    oACG_CASelect,
    output logic [39:0]                             oACG_CAData
);

    always_comb begin
        oACG_Command       = IdleCommand;
        oACG_CommandOption = IdleCommandOption;
        oACG_TargetWay     = '0;
        oACG_NumOfData     = IdleNumOfData;
        oACG_CASelect      = IdleCASelect;
        oACG_CAData        = IdleCAData;
        for (int k = 0; k < NumOfCmdModules; k++) begin
            if (iActive && iGrant == 3'(k)) begin
                oACG_Command       = iCM_Command[8*k +: 8];
                oACG_CommandOption = iCM_CommandOption[3*k +: 3];
                oACG_TargetWay     = iCM_TargetWay[NumberOfWays*k +: NumberOfWays];
                oACG_NumOfData     = iCM_NumOfData[16*k +: 16];
                oACG_CASelect      = iCM_CASelect[k];
                oACG_CAData        = iCM_CAData[40*k +: 40];
            end
        end
    end

endmodule

// File: rtl/nfc_command_dispatcher.sv
// nfc_command_dispatcher: grants the shared ACG bus to one command sequencer at a time
//   iSystemClock / iReset   clock, synchronous active-high reset
//   iCM_Start/LastStep      per-sequencer accept strobe and completion pulse
//   iCM_CMDReady            per-sequencer ready, all must be high for oCMDReady
//   iCM_*                   packed per-sequencer ACG fields
//   oCMDReady               host may issue a command
//   oLastStep / oTimeout    1-cycle pulses: granted command finished / watchdog expired
//   oActiveID / oBusy       granted sequencer index and grant-held flag
//   oCollision              sticky: overlapping or mid-command starts
//   oACG_*                  shared ACG bus
module nfc_command_dispatcher
    import nfc_command_dispatcher_pkg::*;
#(
    parameter int          NumberOfWays    = 4,
    parameter int          NumOfCmdModules = 4,
    parameter int unsigned TimeoutCycles   = 32'd1 << 20
) (
    input  logic                                    iSystemClock,
    input  logic                                    iReset,
    input  logic [NumOfCmdModules-1:0]              iCM_Start,
    input  logic [NumOfCmdModules-1:0]              iCM_LastStep,
    input  logic [NumOfCmdModules-1:0]              iCM_CMDReady,
    input  logic [8*NumOfCmdModules-1:0]            iCM_Command,
    input  logic [3*NumOfCmdModules-1:0]            iCM_CommandOption,
    input  logic [NumberOfWays*NumOfCmdModules-1:0] iCM_TargetWay,
    input  logic [16*NumOfCmdModules-1:0]           iCM_NumOfData,
    input  logic [NumOfCmdModules-1:0]              iCM_CASelect,
    input  logic [40*NumOfCmdModules-1:0]           iCM_CAData,
    output logic                                    oCMDReady,
    output logic                                    oLastStep,
    output logic [2:0]                              oActiveID,
    output logic                                    oBusy,
    output logic                                    oTimeout,
    output logic                                    oCollision,
    output logic [7:0]                              oACG_Command,
    output logic [2:0]                              oACG_CommandOption,
    output logic [NumberOfWays-1:0]                 oACG_TargetWay,
    output logic [15:0]                             oACG_NumOfData,
    output logic                                    oACG_CASelect,
    output logic [39:0]                             oACG_CAData
);

    dispState_t  state;
    logic [2:0]  grant;
    logic [2:0]  startIdx;
    logic [31:0] watchdog;
    logic        lastGranted;
    logic        multiStart;
    logic        wdExpire;

    // Lowest set start bit wins; completion is taken only from the granted sequencer.
    always_comb begin
        startIdx = '0;
        for (int k = NumOfCmdModules - 1; k >= 0; k--)
            if (iCM_Start[k]) startIdx = 3'(k);
        lastGranted = 1'b0;
        for (int k = 0; k < NumOfCmdModules; k++)
            if (grant == 3'(k)) lastGranted = iCM_LastStep[k];
    end

    assign multiStart = $countones(iCM_Start) > 1;
    assign wdExpire   = (TimeoutCycles != 0) && (watchdog == TimeoutCycles - 1);
    assign oCMDReady  = (state == sIdle) & (&iCM_CMDReady);
    assign oActiveID  = grant;

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state      <= sIdle;
            grant      <= '0;
            watchdog   <= '0;
            oLastStep  <= 1'b0;
            oTimeout   <= 1'b0;
            oCollision <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            oLastStep <= 1'b0;
            oTimeout  <= 1'b0;
            if ((state == sIdle) ? multiStart : |iCM_Start)
                oCollision <= 1'b1;
            case (state)
                sIdle: if (|iCM_Start) begin
                    state    <= sActive;
                    grant    <= startIdx;
                    watchdog <= '0;
                    oBusy    <= 1'b1;
                end
                sActive: begin
                    if (watchdog != '1)
                        watchdog <= watchdog + 32'd1;
                    // Completion takes priority over a simultaneous watchdog expiry.
                    if (lastGranted) begin
                        state     <= sDone;
                        oLastStep <= 1'b1;
                    end else if (wdExpire) begin
                        state    <= sTout;
                        oTimeout <= 1'b1;
                    end
                end
                default: begin
                    state <= sIdle;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

    nfc_acg_bus_mux #(
        .NumberOfWays   (NumberOfWays),
        .NumOfCmdModules(NumOfCmdModules)
    ) uBusMux (
        .iGrant            (grant),
        .iActive           (state == sActive),
        .iCM_Command       (iCM_Command),
        .iCM_CommandOption (iCM_CommandOption),
        .iCM_TargetWay     (iCM_TargetWay),
        .iCM_NumOfData     (iCM_NumOfData),
        .iCM_CASelect      (iCM_CASelect),
        .iCM_CAData        (iCM_CAData),
        .oACG_Command      (oACG_Command),
        .oACG_CommandOption(oACG_CommandOption),
        .oACG_TargetWay    (oACG_TargetWay),
        .oACG_NumOfData    (oACG_NumOfData),
        .oACG_CASelect     (oACG_CASelect),
        .oACG_CAData       (oACG_CAData)
    );

endmodule

// File: tb/tb_nfc_command_dispatcher.sv
// tb_nfc_command_dispatcher: scoreboard bench for the ACG command dispatcher
module tb_nfc_command_dispatcher;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   start, lastStep, cmdReady, caSel;
    logic [31:0]  cmd;
    logic [11:0]  opt;
    logic [15:0]  tway;
    logic [63:0]  nod;
    logic [159:0] cad;
    logic         cmdRdyOut, lastOut, busy, tout, coll, acgCaSel;
    logic [2:0]   activeId, acgOpt;
    logic [7:0]   acgCmd;
    logic [3:0]   acgWay;
    logic [15:0]  acgNod;
    logic [39:0]  acgCad;

    typedef struct {
        bit         isTout;
        logic [2:0] id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nfc_command_dispatcher #(
        .NumberOfWays   (4),
        .NumOfCmdModules(4),
        .TimeoutCycles  (16)
    ) dut (
        .iSystemClock      (clk),
        .iReset            (rst),
        .iCM_Start         (start),
        .iCM_LastStep      (lastStep),
        .iCM_CMDReady      (cmdReady),
        .iCM_Command       (cmd),
        .iCM_CommandOption (opt),
        .iCM_TargetWay     (tway),
        .iCM_NumOfData     (nod),
        .iCM_CASelect      (caSel),
        .iCM_CAData        (cad),
        .oCMDReady         (cmdRdyOut),
        .oLastStep         (lastOut),
        .oActiveID         (activeId),
        .oBusy             (busy),
        .oTimeout          (tout),
        .oCollision        (coll),
        .oACG_Command      (acgCmd),
        .oACG_CommandOption(acgOpt),
        .oACG_TargetWay    (acgWay),
        .oACG_NumOfData    (acgNod),
        .oACG_CASelect     (acgCaSel),
        .oACG_CAData       (acgCad)
    );

    // Every completion/timeout pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (lastOut || tout) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse lastStep=%b timeout=%b id=%0d, required no pulse", lastOut, tout, activeId);
            end else begin
                e = sb.pop_front();
                if ({tout, lastOut, activeId} !== {e.isTout, !e.isTout, e.id}) begin
                    errors++;
                    $display("FAIL pulse timeout/last/id=%b/%b/%0d required %b/%b/%0d", tout, lastOut, activeId, e.isTout, !e.isTout, e.id);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({busy, acgCmd, acgOpt, acgWay, acgNod, acgCaSel, acgCad} !== {1'b0, 8'h00, 3'd0, 4'd0, 16'd0, 1'b1, 40'd0}) begin
            errors++;
            $display("FAIL %s busy=%b cmd=%h opt=%0d way=%b nod=%0d casel=%b cad=%h, required idle pattern with busy=0", name, busy, acgCmd, acgOpt, acgWay, acgNod, acgCaSel, acgCad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = '0; lastStep = '0; cmdReady = 4'hF; caSel = 4'b0000;
        cmd  = 32'h80_08_02_01;
        opt  = {3'd4, 3'd3, 3'd2, 3'd1};
        tway = 16'h8421;
        nod  = {16'd400, 16'd300, 16'd200, 16'd100};
        cad  = {40'h33_0000_0003, 40'h80_0000_0000, 40'h11_0000_0001, 40'h00_0000_0010};
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_idle("reset_idle");
        checks++;
        if ({cmdRdyOut, coll, lastOut, tout, activeId} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_flags ready/coll/last/tout/id=%b/%b/%b/%b/%0d required 1/0/0/0/0", cmdRdyOut, coll, lastOut, tout, activeId);
        end
        cmdReady = 4'b1011;
        #1;
        checks++;
        if (cmdRdyOut !== 1'b0) begin
            errors++;
            $display("FAIL ready_gated cmdReady=%b required 0", cmdRdyOut);
        end
        cmdReady = 4'hF;
    endtask

    task automatic test_command();
        start = 4'b0100;
        sb.push_back('{isTout: 1'b0, id: 3'd2});
        tick();
        start = '0;
        checks++;
        if ({busy, activeId, acgCmd, acgOpt, acgWay, acgNod, acgCaSel, acgCad, cmdRdyOut} !==
            {1'b1, 3'd2, 8'h08, 3'd3, 4'b0100, 16'd300, 1'b0, 40'h80_0000_0000, 1'b0}) begin
            errors++;
            $display("FAIL grant_seq2 busy=%b id=%0d cmd=%h opt=%0d way=%b nod=%0d casel=%b cad=%h ready=%b required 1/2/08/3/0100/300/0/8000000000/0",
                     busy, activeId, acgCmd, acgOpt, acgWay, acgNod, acgCaSel, acgCad, cmdRdyOut);
        end
        repeat (4) tick();
        lastStep = 4'b0001;
        tick();
        lastStep = '0;
        checks++;
        if ({busy, acgCmd, activeId} !== {1'b1, 8'h08, 3'd2}) begin
            errors++;
            $display("FAIL foreign_laststep busy=%b cmd=%h id=%0d required 1/08/2", busy, acgCmd, activeId);
        end
        repeat (4) tick();
        lastStep = 4'b0100;
        tick();
        lastStep = '0;
        checks++;
        if ({lastOut, tout, busy} !== 3'b101) begin
            errors++;
            $display("FAIL done_state last/tout/busy=%b%b%b required 101", lastOut, tout, busy);
        end
        checks++;
        if ({acgCmd, acgCaSel, acgCad} !== {8'h00, 1'b1, 40'd0}) begin
            errors++;
            $display("FAIL done_idle_bus cmd=%h casel=%b cad=%h required 00/1/0", acgCmd, acgCaSel, acgCad);
        end
        tick();
        checks++;
        if ({busy, cmdRdyOut, lastOut} !== 3'b010) begin
            errors++;
            $display("FAIL after_done busy/ready/last=%b%b%b required 010", busy, cmdRdyOut, lastOut);
        end
    endtask

    task automatic test_collision();
        start = 4'b0110;
        sb.push_back('{isTout: 1'b0, id: 3'd1});
        tick();
        start = '0;
        checks++;
        if ({activeId, coll, acgCmd} !== {3'd1, 1'b1, 8'h02}) begin
            errors++;
            $display("FAIL multi_start id=%0d coll=%b cmd=%h required 1/1/02", activeId, coll, acgCmd);
        end
        lastStep = 4'b0010;
        tick();
        lastStep = '0;
        tick();
        checks++;
        if ({coll, busy} !== 2'b10) begin
            errors++;
            $display("FAIL coll_sticky coll=%b busy=%b required 1/0", coll, busy);
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        start = 4'b0001;
        sb.push_back('{isTout: 1'b1, id: 3'd0});
        tick();
        start = '0;
        repeat (15) begin
            tick();
            if (!busy || tout || lastOut || acgCmd !== 8'h01) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early bad_cycles=%0d required 0", bad);
        end
        tick();
        checks++;
        if ({tout, lastOut, busy, acgCmd, acgCaSel} !== {1'b1, 1'b0, 1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL timeout_pulse tout=%b last=%b busy=%b cmd=%h casel=%b required 1/0/1/00/1", tout, lastOut, busy, acgCmd, acgCaSel);
        end
        tick();
        checks++;
        if ({busy, tout, cmdRdyOut, coll} !== 4'b0011) begin
            errors++;
            $display("FAIL after_timeout busy/tout/ready/coll=%b required 0011", {busy, tout, cmdRdyOut, coll});
        end
    endtask

    task automatic test_last_vs_timeout();
        start = 4'b0100;
        sb.push_back('{isTout: 1'b0, id: 3'd2});
        tick();
        start = '0;
        repeat (15) tick();
        lastStep = 4'b0100;
        tick();
        lastStep = '0;
        checks++;
        if ({lastOut, tout} !== 2'b10) begin
            errors++;
            $display("FAIL last_wins last=%b tout=%b required 1/0", lastOut, tout);
        end
        tick();
        check_idle("last_wins_idle");
    endtask

    task automatic test_reset_mid_command();
        start = 4'b1000;
        tick();
        start = '0;
        repeat (2) tick();
        checks++;
        if ({busy, activeId, acgCmd} !== {1'b1, 3'd3, 8'h80}) begin
            errors++;
            $display("FAIL pre_reset busy=%b id=%0d cmd=%h required 1/3/80", busy, activeId, acgCmd);
        end
        rst = 1'b1;
        tick();
        check_idle("reset_mid_idle");
        checks++;
        if ({lastOut, tout, coll} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_flags last/tout/coll=%b required 000", {lastOut, tout, coll});
        end
        rst = 1'b0;
        tick();
        check_idle("reset_mid_after");
    endtask

    task automatic test_back_to_back();
        start = 4'b0001;
        sb.push_back('{isTout: 1'b0, id: 3'd0});
        tick();
        start = '0;
        checks++;
        if ({coll, activeId, busy} !== {1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_start coll=%b id=%0d busy=%b required 0/0/1", coll, activeId, busy);
        end
        start = 4'b1000;
        tick();
        start = '0;
        checks++;
        if ({coll, activeId, acgCmd} !== {1'b1, 3'd0, 8'h01}) begin
            errors++;
            $display("FAIL busy_start coll=%b id=%0d cmd=%h required 1/0/01", coll, activeId, acgCmd);
        end
        lastStep = 4'b0001;
        tick();
        lastStep = '0;
        tick();
        start = 4'b0010;
        sb.push_back('{isTout: 1'b0, id: 3'd1});
        tick();
        start = '0;
        checks++;
        if ({activeId, acgCmd, acgWay} !== {3'd1, 8'h02, 4'b0010}) begin
            errors++;
            $display("FAIL back_to_back id=%0d cmd=%h way=%b required 1/02/0010", activeId, acgCmd, acgWay);
        end
        lastStep = 4'b0010;
        tick();
        lastStep = '0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_command();
        test_collision();
        test_timeout();
        test_last_vs_timeout();
        test_reset_mid_command();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
